// File: rtl/datapath_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : datapath_ctrl_fsm
// Purpose  : Multi-cycle control unit for the 16-bit register / ALU /
//            tri-state bus datapath. It accepts one instruction per
//            valid/ready handshake, then steps through IDLE -> T1 [-> T2 -> T3]
//            driving one-hot register-load and bus-driver enables.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk                in   1     rising-edge clock
//   rst_n              in   1     asynchronous active-low reset
//   halt               in   1     (CTRL_HALT_EN only) freeze the current step
//   instr_valid        in   1     instruction presented
//   instr_ready        out  1     controller can accept (IDLE)
//   instr              in   9     {op[8:6], rx[5:3], ry[2:0]}
//   imm                in   16    immediate, sampled with instr
//   r_en_OH            out  EN_W  one-hot register load enables
//   tri_controller_OH  out  EN_W  one-hot bus driver enables
//   code               out  23    [22:20] ALU op, [19:16] zero, [15:0] imm
//   address            out  6     {rx, ry} of the instruction in progress
//   done               out  1     pulse in the final step
// Optional feature
//   CTRL_HALT_EN : adds the halt input. While halt is high the step is
//                  frozen and every output except address is forced low.
// ============================================================================
module datapath_ctrl_fsm #(
    parameter int NUM_GPR = 8,
    parameter int EN_W    = 20,
    parameter int G_IDX   = 9,
    parameter int A_IDX   = 10,
    parameter int IMM_IDX = 11
) (
    input  logic            clk,
    input  logic            rst_n,
`ifdef CTRL_HALT_EN
    input  logic            halt,
`endif
    input  logic            instr_valid,
    output logic            instr_ready,
    input  logic [8:0]      instr,
    input  logic [15:0]     imm,
    output logic [EN_W-1:0] r_en_OH,
    output logic [EN_W-1:0] tri_controller_OH,
    output logic [22:0]     code,
    output logic [5:0]      address,
    output logic            done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_T1   = 2'd1,
        S_T2   = 2'd2,
        S_T3   = 2'd3
    } state_t;

    localparam logic [2:0] c_OP_MV  = 3'b000;
    localparam logic [2:0] c_OP_MVI = 3'b001;
    localparam logic [2:0] c_OP_ADD = 3'b010;
    localparam logic [2:0] c_OP_XOR = 3'b110;
    localparam logic [2:0] c_OP_NOP = 3'b111;

    // One-hot vector with bit idx set.
    function automatic logic [EN_W-1:0] f_sel(input int idx);
        logic [EN_W-1:0] v;
        v = {{(EN_W-1){1'b0}}, 1'b1} << idx;
        return v;
    endfunction

    // Register fields outside R0..R(NUM_GPR-1) turn the instruction into a NOP.
    function automatic logic f_bad(input logic [8:0] ins);
        return (int'(ins[5:3]) >= NUM_GPR) || (int'(ins[2:0]) >= NUM_GPR);
    endfunction

    function automatic logic f_is_alu(input logic [2:0] op);
        return (op >= c_OP_ADD) && (op <= c_OP_XOR);
    endfunction

    // ------------------------------------------------------------------
    // State and latched instruction
    // ------------------------------------------------------------------
    state_t          state_q, state_d;
    logic [8:0]      instr_q, instr_d;
    logic [15:0]     imm_q,   imm_d;

    // Registered outputs
    logic            ready_q, ready_d;
    logic [EN_W-1:0] r_en_q,  r_en_d;
    logic [EN_W-1:0] tri_q,   tri_d;
    logic [22:0]     code_q,  code_d;
    logic [5:0]      addr_q,  addr_d;
    logic            done_q,  done_d;

    logic            w_stall;
    logic            w_accept;
    logic            w_go_alu;

`ifdef CTRL_HALT_EN
    assign w_stall = halt;
`else
    assign w_stall = 1'b0;
`endif

    // ready_q is the registered instr_ready, so the handshake is judged on
    // exactly what the source sees.
    assign w_accept = instr_valid & ready_q & ~w_stall;
    assign w_go_alu = f_is_alu(instr_q[8:6]) & ~f_bad(instr_q);

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        imm_d   = imm_q;
        if (!w_stall) begin
            case (state_q)
                S_IDLE: begin
                    if (w_accept) begin
                        state_d = S_T1;
                        instr_d = instr;
                        imm_d   = imm;
                    end
                end
                S_T1:    state_d = w_go_alu ? S_T2 : S_IDLE;
                S_T2:    state_d = S_T3;
                S_T3:    state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output decode of the upcoming state. Registering the result gives
    // glitch-free Moore outputs aligned with the step they belong to.
    // ------------------------------------------------------------------
    logic [2:0] w_op_d;
    int         w_rx_d;
    int         w_ry_d;

    assign w_op_d = instr_d[8:6];
    assign w_rx_d = int'(instr_d[5:3]);
    assign w_ry_d = int'(instr_d[2:0]);

    always_comb begin
        ready_d = 1'b0;
        r_en_d  = '0;
        tri_d   = '0;
        code_d  = '0;
        addr_d  = '0;
        done_d  = 1'b0;
        case (state_d)
            S_IDLE: ready_d = 1'b1;
            S_T1: begin
                addr_d = instr_d[5:0];
                if (f_bad(instr_d)) begin
                    done_d = 1'b1;
                end else begin
                    case (w_op_d)
                        c_OP_MV: begin
                            tri_d  = f_sel(w_ry_d);
                            r_en_d = f_sel(w_rx_d);
                            done_d = 1'b1;
                        end
                        c_OP_MVI: begin
                            tri_d         = f_sel(IMM_IDX);
                            code_d[15:0]  = imm_d;
                            r_en_d        = f_sel(w_rx_d);
                            done_d        = 1'b1;
                        end
                        c_OP_NOP: done_d = 1'b1;
                        default: begin
                            // ALU step 1: rx -> A
                            tri_d  = f_sel(w_rx_d);
                            r_en_d = f_sel(A_IDX);
                        end
                    endcase
                end
            end
            S_T2: begin
                // ALU step 2: A op ry -> G
                addr_d         = instr_d[5:0];
                tri_d          = f_sel(w_ry_d);
                r_en_d         = f_sel(G_IDX);
                code_d[22:20]  = w_op_d - c_OP_ADD;
            end
            S_T3: begin
                // ALU step 3: G -> rx
                addr_d = instr_d[5:0];
                tri_d  = f_sel(G_IDX);
                r_en_d = f_sel(w_rx_d);
                done_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            instr_q <= '0;
            imm_q   <= '0;
            ready_q <= 1'b0;
            r_en_q  <= '0;
            tri_q   <= '0;
            code_q  <= '0;
            addr_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            imm_q   <= imm_d;
            ready_q <= ready_d;
            r_en_q  <= r_en_d;
            tri_q   <= tri_d;
            code_q  <= code_d;
            addr_q  <= addr_d;
            done_q  <= done_d;
        end
    end

    // address is never masked so the datapath keeps its operand selection
    // stable across a halt.
    assign address = addr_q;

`ifdef CTRL_HALT_EN
    assign instr_ready       = ready_q & ~halt;
    assign r_en_OH           = halt ? '0 : r_en_q;
    assign tri_controller_OH = halt ? '0 : tri_q;
    assign code              = halt ? '0 : code_q;
    assign done              = done_q & ~halt;
`else
    assign instr_ready       = ready_q;
    assign r_en_OH           = r_en_q;
    assign tri_controller_OH = tri_q;
    assign code              = code_q;
    assign done              = done_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_datapath_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_datapath_ctrl_fsm
// Purpose  : Self-checking bench for datapath_ctrl_fsm. A reference model
//            pushes the expected per-step outputs of each instruction into a
//            queue when it is driven; each cycle the front entry is popped
//            and compared with the DUT outputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_datapath_ctrl_fsm;

    localparam int EN_W = 20;

    logic            clk;
    logic            rst_n;
    logic            instr_valid;
    logic            instr_ready;
    logic [8:0]      instr;
    logic [15:0]     imm;
    logic [EN_W-1:0] r_en_OH;
    logic [EN_W-1:0] tri_controller_OH;
    logic [22:0]     code;
    logic [5:0]      address;
    logic            done;
`ifdef CTRL_HALT_EN
    logic            halt;
`endif

    datapath_ctrl_fsm dut (
        .clk               (clk),
        .rst_n             (rst_n),
`ifdef CTRL_HALT_EN
        .halt              (halt),
`endif
        .instr_valid       (instr_valid),
        .instr_ready       (instr_ready),
        .instr             (instr),
        .imm               (imm),
        .r_en_OH           (r_en_OH),
        .tri_controller_OH (tri_controller_OH),
        .code              (code),
        .address           (address),
        .done              (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic            ready;
        logic [EN_W-1:0] ren;
        logic [EN_W-1:0] tri_oh;
        logic [22:0]     code;
        logic [5:0]      addr;
        logic            done;
    } step_t;

    typedef struct {
        logic [8:0]  ins;
        logic [15:0] im;
        int          steps;   // expected cycles from accept to done
        string       name;
    } vec_t;

    step_t exp_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    function automatic logic [EN_W-1:0] bit_at(input int i);
        logic [EN_W-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic step_t idle_step();
        step_t s;
        s       = '0;
        s.ready = 1'b1;
        return s;
    endfunction

    function automatic step_t dut_now();
        return {instr_ready, r_en_OH, tri_controller_OH, code, address, done};
    endfunction

    // Reference model: expected visible outputs for each step.
    task automatic push_model(input logic [8:0] ins, input logic [15:0] im);
        step_t s;
        int rx, ry;
        logic [2:0] alu;
        rx = int'(ins[5:3]);
        ry = int'(ins[2:0]);
        s = '0;
        s.addr = ins[5:0];
        case (ins[8:6])
            3'b000: begin
                s.tri_oh = bit_at(ry); s.ren = bit_at(rx); s.done = 1'b1;
                exp_q.push_back(s);
            end
            3'b001: begin
                s.tri_oh = bit_at(11); s.code = {7'b0, im};
                s.ren = bit_at(rx); s.done = 1'b1;
                exp_q.push_back(s);
            end
            3'b111: begin
                s.done = 1'b1;
                exp_q.push_back(s);
            end
            default: begin
                case (ins[8:6])
                    3'b010:  alu = 3'd0;
                    3'b011:  alu = 3'd1;
                    3'b100:  alu = 3'd2;
                    3'b101:  alu = 3'd3;
                    default: alu = 3'd4;
                endcase
                s.tri_oh = bit_at(rx); s.ren = bit_at(10);
                exp_q.push_back(s);
                s.tri_oh = bit_at(ry); s.ren = bit_at(9); s.code = {alu, 20'h0};
                exp_q.push_back(s);
                s.tri_oh = bit_at(9); s.ren = bit_at(rx); s.code = '0; s.done = 1'b1;
                exp_q.push_back(s);
            end
        endcase
    endtask

    task automatic check_now(input string name, input step_t e);
        step_t a;
        a = dut_now();
        n_tests++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got rdy=%b ren=%h tri=%h code=%h addr=%o done=%b, want rdy=%b ren=%h tri=%h code=%h addr=%o done=%b",
                     name, a.ready, a.ren, a.tri_oh, a.code, a.addr, a.done,
                     e.ready, e.ren, e.tri_oh, e.code, e.addr, e.done);
        end
    endtask

    task automatic check_step(input string name);
        if (exp_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            check_now(name, exp_q.pop_front());
        end
    endtask

    task automatic wait_ready(input string name);
        int t = 0;
        while (instr_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) begin
            n_tests++; n_fail++;
            $display("FAIL %s: instr_ready timeout, got %b want 1", name, instr_ready);
        end
    endtask

    // Every cycle out of reset: at most one enable per vector.
    always @(negedge clk) begin
        if (rst_n) begin
            n_tests++;
            if (!$onehot0(tri_controller_OH) || !$onehot0(r_en_OH)) begin
                n_fail++;
                $display("FAIL onehot: tri=%h ren=%h, want at most one bit each",
                         tri_controller_OH, r_en_OH);
            end
        end
    end

    task automatic run_vec(input vec_t v);
        int cyc, got_done;
        wait_ready(v.name);
        instr_valid = 1'b1;
        instr       = v.ins;
        imm         = v.im;
        push_model(v.ins, v.im);
        @(negedge clk);
        instr_valid = 1'b0;
        instr       = '0;
        imm         = '0;
        cyc = 0;
        got_done = 0;
        while (exp_q.size() > 0) begin
            cyc++;
            if (done === 1'b1 && got_done == 0) got_done = cyc;
            check_step(v.name);
            if (exp_q.size() > 0) @(negedge clk);
        end
        n_tests++;
        if (got_done != v.steps) begin
            n_fail++;
            $display("FAIL %s_latency: done at cycle %0d, want %0d", v.name, got_done, v.steps);
        end
        @(negedge clk);
        check_now({v.name, "_idle"}, idle_step());
    endtask

    vec_t  vecs[8];
    step_t s;

    initial begin
        vecs[0] = '{9'b001_011_000, 16'h00A5, 1, "mvi_r3"};
        vecs[1] = '{9'b000_001_011, 16'h1234, 1, "mv_r1_r3"};
        vecs[2] = '{9'b011_001_010, 16'h0000, 3, "sub_r1_r2"};
        vecs[3] = '{9'b010_010_010, 16'h0000, 3, "add_r2_r2"};
        vecs[4] = '{9'b100_100_101, 16'h0000, 3, "and_r4_r5"};
        vecs[5] = '{9'b101_111_000, 16'hFFFF, 3, "or_r7_r0"};
        vecs[6] = '{9'b111_010_001, 16'h5555, 1, "nop"};
        vecs[7] = '{9'b001_000_111, 16'hFFFF, 1, "mvi_r0_ffff"};

        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr       = '0;
        imm         = '0;
`ifdef CTRL_HALT_EN
        halt        = 1'b0;
`endif
        #1;
        check_now("reset_low", '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_now("reset_idle", idle_step());

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // XOR R3,R5 then MV R5,R6 with instr_valid held high throughout.
        wait_ready("xor_mv");
        instr_valid = 1'b1;
        instr       = 9'b110_011_101;
        push_model(9'b110_011_101, 16'h0);
        exp_q.push_back(idle_step());
        push_model(9'b000_101_110, 16'h0);
        @(negedge clk);
        check_step("xor_t1");
        instr = 9'b000_101_110;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            check_step("xor_mv_seq");
        end
        instr_valid = 1'b0;
        @(negedge clk);
        check_now("xor_mv_idle", idle_step());

        // Reset during T2 of ADD R2,R3.
        wait_ready("rst_mid");
        instr_valid = 1'b1;
        instr       = 9'b010_010_011;
        push_model(9'b010_010_011, 16'h0);
        @(negedge clk);
        instr_valid = 1'b0;
        check_step("rst_add_t1");
        @(negedge clk);
        check_step("rst_add_t2");
        exp_q.delete();
        #2 rst_n = 1'b0;
        #1 check_now("rst_async", '0);
        @(negedge clk);
        check_now("rst_held", '0);
        rst_n = 1'b1;
        @(negedge clk);
        check_now("rst_release_idle", idle_step());
        @(negedge clk);
        check_now("rst_no_writeback", idle_step());

`ifdef CTRL_HALT_EN
        // Halt for three edges during T2 of AND R4,R5.
        wait_ready("halt");
        instr_valid = 1'b1;
        instr       = 9'b100_100_101;
        push_model(9'b100_100_101, 16'h0);
        @(negedge clk);
        instr_valid = 1'b0;
        check_step("halt_t1");
        @(negedge clk);
        check_step("halt_t2");
        halt = 1'b1;
        s = '0;
        s.addr = 6'o45;
        #1 check_now("halt_zero0", s);
        @(negedge clk);
        check_now("halt_zero1", s);
        @(negedge clk);
        check_now("halt_zero2", s);
        @(negedge clk);
        halt = 1'b0;
        s.tri_oh = bit_at(5);
        s.ren    = bit_at(9);
        s.code   = {3'b010, 20'h0};
        #1 check_now("halt_t2_reissue", s);
        @(negedge clk);
        check_step("halt_t3");
        @(negedge clk);
        check_now("halt_idle", idle_step());
        // Halt in IDLE blocks acceptance.
        halt = 1'b1;
        instr_valid = 1'b1;
        instr = 9'b000_001_010;
        @(negedge clk);
        s = '0;
        check_now("halt_idle_block", s);
        instr_valid = 1'b0;
        halt = 1'b0;
        @(negedge clk);
        check_now("halt_idle_resume", idle_step());
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
